load_align_extend: RTL and testbench
====================================

# load_align_extend

Load-path unit between the datapath and data memory for byte, halfword and word loads. It accepts a load request, issues one or two word-aligned memory reads and extracts the addressed bytes. It then sign- or zero-extends the result to the full data width and returns it over a valid/ready handshake. It is the parametrised, multi-cycle successor to the fixed 16-to-32 halfword sign extender and adds alignment, unsigned loads and misaligned-access handling.

## Interface
- DATA_W, 32: word width in bits; power of two, ≥ 16.
- ADDR_W, 32: byte-address width.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_signed  in  1  1 = sign-extend, 0 = zero-extend.
- mem_rd_en  out  1  memory read strobe; one cycle per read.
- mem_addr  out  ADDR_W  word-aligned read address; low log2(DATA_W/8) bits are always 0.
- mem_rd_data  in  DATA_W  read data, valid the cycle after mem_rd_en.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_W  aligned, extended load result.
- rsp_err  out  1  request faulted; rsp_data is 0 when set.

## Operation
- **Byte order:** little-endian. off = req_addr mod (DATA_W/8). nbytes = 1, 2 or DATA_W/8 according to req_size.
- **Misaligned:** off is not a multiple of nbytes.
- **Split:** off + nbytes > DATA_W/8, so the access crosses a word boundary.
- **Capture:** a request is captured on req_valid && req_ready.
- **FSM states:** IDLE, RD0, RD1, CAP, RESP.
- **IDLE:**
  - req_size = 3 → RESP with rsp_err = 1.
  - Misaligned with the macro off → RESP with rsp_err = 1.
  - Otherwise → RD0.
- **RD0:** mem_rd_en = 1, mem_addr = word base of req_addr. Next state is RD1 if the access splits, else CAP.
- **RD1:** mem_rd_en = 1, mem_addr = base + DATA_W/8. Captures word0 from mem_rd_data. Next state is CAP.
- **CAP:**
  - Captures the last word.
  - Forms the 2·DATA_W value {word1, word0}; word1 = 0 if not split.
  - Shifts that value right by 8·off and keeps the low 8·nbytes bits.
  - Fills the upper bits with bit 8·nbytes−1 if req_signed, else with 0.
  - Registers the result into rsp_data. Next state is RESP.
- **RESP:** rsp_valid = 1. rsp_data and rsp_err are held stable until rsp_ready, then the FSM returns to IDLE.
- **Word loads:** a word load with nbytes = DATA_W/8 needs no extension; req_signed is ignored.
- **Errored requests:** no memory read is issued.
- **Reset values:** req_ready 1, mem_rd_en 0, mem_addr 0, rsp_valid 0, rsp_data 0, rsp_err 0, state IDLE.
- **Reset mid-operation:** the request in flight is discarded; no response is produced.

## Timing
- T = request capture cycle.
- **Aligned / non-split:** RD0 at T+1, CAP at T+2, rsp_valid at T+3.
- **Split:** RD0 at T+1, RD1 at T+2, CAP at T+3, rsp_valid at T+4.
- **Error:** rsp_valid at T+1.
- **Throughput:** one request in flight. req_ready rises the cycle after the response handshake, so at most one request completes every 4 cycles (aligned).
- **rsp_ready:** rsp_ready held high earlier than RESP has no effect.

## Configuration
- LOAD_MISALIGNED_EN defined:
  - Misaligned accesses are serviced.
  - Non-split ones take the single-read path, e.g. a halfword at off 1 with DATA_W = 32.
  - Split ones take the two-read path.
- Undefined:
  - Every misaligned access returns rsp_err = 1 and rsp_data = 0.
  - RD1 is unreachable and may be removed by synthesis.

## Structure
- **Package load_pkg:**
  - size encoding enum: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD.
  - FSM state enum.
  - helper functions for nbytes and the misaligned and split predicates.
  - The package is parametrised by DATA_W via functions taking the width.
- **Sub-module load_extract:** combinational. Inputs: {word1, word0}, off, size, signed. Output: the extended result. It is the generalised sign/zero extender and is instantiated once, feeding the CAP register.

## Test plan
All scenarios use DATA_W = 32, mem[0x100] = 0x87654321, mem[0x104] = 0x000000A9.
- **Signed half:** signed half at 0x102 → rsp_data 0xFFFF8765, rsp_err 0, rsp_valid at T+3, single mem_rd_en at 0x100.
- **Byte loads:**
  - unsigned byte at 0x103 → 0x00000087.
  - signed byte at 0x103 → 0xFFFFFF87.
  - signed byte at 0x100 → 0x00000021.
- **Split half, macro on:** signed half at 0x103 → reads 0x100 then 0x104, rsp_data 0xFFFFA987, rsp_valid at T+4.
- **Split half, macro off:** same request → rsp_err 1, rsp_data 0, no mem_rd_en, rsp_valid at T+1.
- **Backpressure and reserved size:**
  - Hold rsp_ready = 0 for 5 cycles → rsp_valid and rsp_data stable and req_ready 0 throughout; req_ready returns one cycle after the handshake.
  - req_size = 3 → rsp_err 1, rsp_data 0.
- **Reset mid-op:** assert reset during RD1 → next cycle all outputs at reset values, no response emitted. A subsequent word load at 0x100 returns 0x87654321.

Source files
------------

// File: rtl/load_pkg.sv
// Shared types and width-parametrised helpers for the load alignment/extension path.
package load_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_RSVD = 2'd3
   } size_e;

   typedef enum logic [2:0] {
      IDLE,
      RD0,
      RD1,
      CAP,
      RESP
   } state_e;

   // Reserved sizes map to a full word; they are rejected before this matters.
   function automatic int unsigned size_bytes(input size_e size, input int unsigned data_w);
      case (size)
         SZ_BYTE: return 1;
         SZ_HALF: return 2;
         default: return data_w / 8;
      endcase
   endfunction

   function automatic logic is_misaligned(input int unsigned off, input size_e size,
                                          input int unsigned data_w);
      return (off % size_bytes(size, data_w)) != 0;
   endfunction

   function automatic logic is_split(input int unsigned off, input size_e size,
                                     input int unsigned data_w);
      return (off + size_bytes(size, data_w)) > (data_w / 8);
   endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte extractor and sign/zero extender over a two-word window {word1, word0}.
module load_extract
   import load_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OFF_W  = 2
) (
   input  logic [2*DATA_W-1:0] words,
   input  logic [OFF_W-1:0]    off,
   input  size_e               size,
   input  logic                sign_ext,
   output logic [DATA_W-1:0]   result
);

   logic [DATA_W-1:0] low;

   // Little-endian: the addressed byte lands in bit 0 after shifting by 8*off.
   assign low = DATA_W'(words >> {off, 3'b000});

   always_comb begin
      result = low;
      case (size)
         SZ_BYTE: result = {{(DATA_W-8){sign_ext & low[7]}}, low[7:0]};
         SZ_HALF: result = {{(DATA_W-16){sign_ext & low[15]}}, low[15:0]};
         default: result = low;
      endcase
   end

endmodule

// File: rtl/load_align_extend.sv
// Multi-cycle load path: word-aligned reads, byte extraction and extension, valid/ready response.
// Define LOAD_MISALIGNED_EN to service misaligned accesses instead of faulting them.
module load_align_extend
   import load_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err
);

   localparam int OFF_W      = $clog2(DATA_W / 8);
   localparam int WORD_BYTES = DATA_W / 8;

   state_e              state;
   size_e               req_sz;
   size_e               size_q;
   logic [OFF_W-1:0]    off_q;
   logic                sign_q;
   logic                split_q;
   logic [ADDR_W-1:0]   base_q;
   logic [ADDR_W-1:0]   req_base;
   logic [DATA_W-1:0]   word0_q;
   logic [DATA_W-1:0]   extracted;
   logic [2*DATA_W-1:0] words;
   logic                misaligned;
   logic                split;
   logic                reject;

   assign req_sz     = size_e'(req_size);
   assign req_base   = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign misaligned = is_misaligned(32'(req_addr[OFF_W-1:0]), req_sz, DATA_W);
   assign split      = is_split(32'(req_addr[OFF_W-1:0]), req_sz, DATA_W);

`ifdef LOAD_MISALIGNED_EN
   assign reject = (req_sz == SZ_RSVD);
`else
   assign reject = (req_sz == SZ_RSVD) || misaligned;
`endif

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);

   // In CAP the last-read word is on mem_rd_data; word1 is zero for single-read accesses.
   assign words = split_q ? {mem_rd_data, word0_q} : {{DATA_W{1'b0}}, mem_rd_data};

   load_extract #(
      .DATA_W (DATA_W),
      .OFF_W  (OFF_W)
   ) u_extract (
      .words    (words),
      .off      (off_q),
      .size     (size_q),
      .sign_ext (sign_q),
      .result   (extracted)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         mem_rd_en <= 1'b0;
         mem_addr  <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         size_q    <= SZ_BYTE;
         off_q     <= '0;
         sign_q    <= 1'b0;
         split_q   <= 1'b0;
         base_q    <= '0;
         word0_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  size_q   <= req_sz;
                  off_q    <= req_addr[OFF_W-1:0];
                  sign_q   <= req_signed;
                  split_q  <= split;
                  base_q   <= req_base;
                  rsp_data <= '0;
                  if (reject) begin
                     rsp_err <= 1'b1;
                     state   <= RESP;
                  end else begin
                     rsp_err   <= 1'b0;
                     mem_rd_en <= 1'b1;
                     mem_addr  <= req_base;
                     state     <= RD0;
                  end
               end
            end
            RD0: begin
               if (split_q) begin
                  mem_addr <= base_q + ADDR_W'(WORD_BYTES);
                  state    <= RD1;
               end else begin
                  mem_rd_en <= 1'b0;
                  state     <= CAP;
               end
            end
            RD1: begin
               word0_q   <= mem_rd_data;
               mem_rd_en <= 1'b0;
               state     <= CAP;
            end
            CAP: begin
               rsp_data <= extracted;
               state    <= RESP;
            end
            RESP: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_align_extend.sv
// Directed scoreboard bench for load_align_extend with a two-word memory model at 0x100/0x104.
module tb_load_align_extend;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_signed;
   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_rd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;

   typedef struct {
      string       tag;
      logic [31:0] data;
      logic        err;
      int          lat;
      int          nreads;
      logic [31:0] a0;
      logic [31:0] a1;
   } expect_t;

   expect_t     sb[$];
   logic [31:0] readLog[$];
   int          nCompared;
   int          nMismatched;
   int          latency;

   load_align_extend #(.DATA_W(32), .ADDR_W(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_size    (req_size),
      .req_signed  (req_signed),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      case (a)
         32'h100: return 32'h87654321;
         32'h104: return 32'h000000A9;
         default: return 32'hDEADBEEF;
      endcase
   endfunction

   // Read data appears the cycle after the strobe.
   initial mem_rd_data = '0;
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= memWord(mem_addr);

   always @(negedge clk) if (mem_rd_en) readLog.push_back(mem_addr);

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      expect_t e;
      e = sb.pop_front();
      checkValue({e.tag, ".data"}, rsp_data, e.data);
      checkValue({e.tag, ".err"}, 32'(rsp_err), 32'(e.err));
      checkValue({e.tag, ".latency"}, 32'(latency), 32'(e.lat));
      checkValue({e.tag, ".nreads"}, 32'(readLog.size()), 32'(e.nreads));
      if (e.nreads > 0 && readLog.size() > 0) checkValue({e.tag, ".addr0"}, readLog[0], e.a0);
      if (e.nreads > 1 && readLog.size() > 1) checkValue({e.tag, ".addr1"}, readLog[1], e.a1);
   endtask

   task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [1:0] size,
                                input logic sgn, input logic [31:0] expData, input logic expErr,
                                input int expLat, input int expReads, input logic [31:0] a0,
                                input logic [31:0] a1, input int hold);
      expect_t e;
      bit      got;
      e.tag = tag; e.data = expData; e.err = expErr; e.lat = expLat;
      e.nreads = expReads; e.a0 = a0; e.a1 = a1;
      sb.push_back(e);
      @(negedge clk);
      checkValue({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
      readLog.delete();
      req_valid  = 1'b1;
      req_addr   = addr;
      req_size   = size;
      req_signed = sgn;
      @(posedge clk);
      #1 req_valid = 1'b0;
      got = 1'b0;
      latency = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            latency = k;
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checkValue({tag, ".timeout_rsp_valid"}, 32'(rsp_valid), 32'd1);
         void'(sb.pop_front());
         return;
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         checkValue({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
         checkValue({tag, ".hold_data"}, rsp_data, sb[0].data);
         checkValue({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
      end
      checkOutput();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      checkValue({tag, ".req_ready_after"}, 32'(req_ready), 32'd1);
      checkValue({tag, ".rsp_valid_after"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      bit sawRsp;
      nCompared   = 0;
      nMismatched = 0;
      reset       = 1'b1;
      req_valid   = 1'b0;
      req_addr    = '0;
      req_size    = 2'd0;
      req_signed  = 1'b0;
      rsp_ready   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkValue("reset.req_ready", 32'(req_ready), 32'd1);
      checkValue("reset.mem_rd_en", 32'(mem_rd_en), 32'd0);
      checkValue("reset.mem_addr", mem_addr, 32'd0);
      checkValue("reset.rsp_valid", 32'(rsp_valid), 32'd0);
      checkValue("reset.rsp_data", rsp_data, 32'd0);
      checkValue("reset.rsp_err", 32'(rsp_err), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      applyStimulus("s_half_102", 32'h102, 2'd1, 1'b1, 32'hFFFF8765, 1'b0, 3, 1, 32'h100, 32'h0, 0);
      applyStimulus("u_half_102", 32'h102, 2'd1, 1'b0, 32'h00008765, 1'b0, 3, 1, 32'h100, 32'h0, 0);
      applyStimulus("u_byte_103", 32'h103, 2'd0, 1'b0, 32'h00000087, 1'b0, 3, 1, 32'h100, 32'h0, 0);
      applyStimulus("s_byte_103", 32'h103, 2'd0, 1'b1, 32'hFFFFFF87, 1'b0, 3, 1, 32'h100, 32'h0, 0);
      applyStimulus("s_byte_100", 32'h100, 2'd0, 1'b1, 32'h00000021, 1'b0, 3, 1, 32'h100, 32'h0, 0);
      applyStimulus("u_half_100", 32'h100, 2'd1, 1'b0, 32'h00004321, 1'b0, 3, 1, 32'h100, 32'h0, 0);
      applyStimulus("s_word_100", 32'h100, 2'd2, 1'b1, 32'h87654321, 1'b0, 3, 1, 32'h100, 32'h0, 0);
      applyStimulus("rsvd_size", 32'h100, 2'd3, 1'b0, 32'h00000000, 1'b1, 1, 0, 32'h0, 32'h0, 0);
`ifdef LOAD_MISALIGNED_EN
      applyStimulus("split_half", 32'h103, 2'd1, 1'b1, 32'hFFFFA987, 1'b0, 4, 2, 32'h100, 32'h104, 0);
      applyStimulus("mis_half_101", 32'h101, 2'd1, 1'b1, 32'h00006543, 1'b0, 3, 1, 32'h100, 32'h0, 0);
`else
      applyStimulus("split_half", 32'h103, 2'd1, 1'b1, 32'h00000000, 1'b1, 1, 0, 32'h0, 32'h0, 0);
      applyStimulus("mis_half_101", 32'h101, 2'd1, 1'b1, 32'h00000000, 1'b1, 1, 0, 32'h0, 32'h0, 0);
`endif
      applyStimulus("backpressure", 32'h102, 2'd1, 1'b1, 32'hFFFF8765, 1'b0, 3, 1, 32'h100, 32'h0, 5);

      // Reset lands two cycles after capture (RD1 for the split request, CAP otherwise).
      @(negedge clk);
      req_valid = 1'b1;
`ifdef LOAD_MISALIGNED_EN
      req_addr = 32'h103; req_size = 2'd1; req_signed = 1'b1;
`else
      req_addr = 32'h100; req_size = 2'd2; req_signed = 1'b0;
`endif
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkValue("midreset.req_ready", 32'(req_ready), 32'd1);
      checkValue("midreset.mem_rd_en", 32'(mem_rd_en), 32'd0);
      checkValue("midreset.mem_addr", mem_addr, 32'd0);
      checkValue("midreset.rsp_valid", 32'(rsp_valid), 32'd0);
      checkValue("midreset.rsp_data", rsp_data, 32'd0);
      checkValue("midreset.rsp_err", 32'(rsp_err), 32'd0);
      sawRsp = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid) sawRsp = 1'b1;
      end
      checkValue("midreset.no_response", 32'(sawRsp), 32'd0);
      applyStimulus("post_reset_word", 32'h100, 2'd2, 1'b0, 32'h87654321, 1'b0, 3, 1, 32'h100, 32'h0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
